// File: rtl/rocket_trace_pkg.sv
// Trace-entry geometry shared by the trace writer and reader.
// Also holds the depth/width derivation helpers and the reader FSM encoding.
package rocket_trace_pkg;

  localparam logic [31:0] ROCKET_TRACE_BASEADDR = 32'h0010_0000;
  localparam int          ROCKET_TRACE_SIZE     = 'h8000;
  localparam int          ROCKET_MEM_DATA_SIZE  = 128;
  localparam int          ROCKET_MEM_ADDR_SIZE  = 32;

  localparam int ENTRY_BYTES     = 32;
  localparam int ENTRY_BYTES_LOG = 5;
  localparam int BEAT_BYTES      = 16;

  function automatic int trace_depth(input int size_bytes);
    return size_bytes / ENTRY_BYTES;
  endfunction

  function automatic int trace_aw(input int depth);
    return $clog2(depth);
  endfunction

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_SEND = 2'd3
  } rd_state_t;

endpackage

// File: rtl/rocket_trace_reader.sv
// Drains the circular trace buffer oldest-to-newest, one 256-bit row as two 128-bit beats.
// 3 cycles per beat with ready high; a stalled sink holds the beat and every output stable.
module rocket_trace_reader
  import rocket_trace_pkg::*;
#(
  parameter logic [31:0] BASEADDR  = ROCKET_TRACE_BASEADDR,
  parameter int          SIZE      = ROCKET_TRACE_SIZE,
  parameter int          DATA_SIZE = ROCKET_MEM_DATA_SIZE,
  parameter int          ADDR_SIZE = ROCKET_MEM_ADDR_SIZE
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic [ADDR_SIZE-1:0] trace_ptr_i,
  input  logic [ADDR_SIZE-1:0] trace_count_i,
  output logic                 trace_mem_en_o,
  output logic [ADDR_SIZE-1:0] trace_mem_addr_o,
  input  logic [DATA_SIZE-1:0] trace_mem_rdata_i,
  output logic                 out_valid_o,
  output logic [DATA_SIZE-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int DEPTH = trace_depth(SIZE);
  localparam int AW    = trace_aw(DEPTH);

  localparam logic [AW:0] REM_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] REM_FULL = {1'b1, {AW{1'b0}}};

  rd_state_t state_q, state_d;

  logic [AW-1:0]        idx_q;
  logic [AW:0]          remaining_q;
  logic                 beat_q;
  logic [DATA_SIZE-1:0] data_q;
  logic                 last_q;
  logic                 empty_done_q;

  logic [AW:0]          snap_n;
  logic [AW-1:0]        snap_idx;
  logic                 start_ok;
  logic                 beat_acc;
  logic [ADDR_SIZE-1:0] row_off;
  logic [ADDR_SIZE-1:0] beat_off;

  logic unused_ptr_bits;
  assign unused_ptr_bits = ^trace_ptr_i[ADDR_SIZE-1:AW];

  // Count saturates at DEPTH; a full buffer starts at the write pointer itself.
  assign snap_n   = (trace_count_i >= ADDR_SIZE'(DEPTH)) ? REM_FULL : trace_count_i[AW:0];
  assign snap_idx = trace_ptr_i[AW-1:0] - snap_n[AW-1:0];
  assign start_ok = (state_q == RD_IDLE) && start_i;
  assign beat_acc = (state_q == RD_SEND) && out_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (start_i && (snap_n != '0)) state_d = RD_REQ;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = RD_SEND;
      RD_SEND: if (out_ready_i) state_d = last_q ? RD_IDLE : RD_REQ;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q        <= '0;
      remaining_q  <= '0;
      beat_q       <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      empty_done_q <= start_ok && (snap_n == '0);
      if (start_ok) begin
        idx_q       <= snap_idx;
        remaining_q <= snap_n;
        beat_q      <= 1'b0;
      end else if (beat_acc) begin
        if (beat_q) begin
          idx_q       <= idx_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
          beat_q      <= 1'b0;
        end else begin
          beat_q <= 1'b1;
        end
      end
      // Payload and last flag only move on the WAIT->SEND edge.
      if (state_q == RD_WAIT) begin
        data_q <= trace_mem_rdata_i;
        last_q <= beat_q && (remaining_q == REM_ONE);
      end
    end
  end

  assign row_off  = ADDR_SIZE'(idx_q) << ENTRY_BYTES_LOG;
  assign beat_off = beat_q ? ADDR_SIZE'(BEAT_BYTES) : '0;

  always_comb begin
    trace_mem_en_o   = 1'b0;
    trace_mem_addr_o = '0;
    out_valid_o      = 1'b0;
    busy_o           = (state_q != RD_IDLE);
    done_o           = empty_done_q;
    case (state_q)
      RD_REQ: begin
        trace_mem_en_o   = 1'b1;
        trace_mem_addr_o = ADDR_SIZE'(BASEADDR) + row_off + beat_off;
      end
      RD_SEND: begin
        out_valid_o = 1'b1;
        done_o      = empty_done_q | (out_ready_i & last_q);
      end
      default: ;
    endcase
  end

  assign out_data_o = data_q;
  assign out_last_o = last_q;

endmodule

// File: tb/tb_rocket_trace_reader.sv
// Randomized bench for rocket_trace_reader against a queue-based model of the drain order.
module tb_rocket_trace_reader;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         start_i = 1'b0;
  logic [31:0]  trace_ptr_i = '0;
  logic [31:0]  trace_count_i = '0;
  logic         trace_mem_en_o;
  logic [31:0]  trace_mem_addr_o;
  logic [127:0] trace_mem_rdata_i = '0;
  logic         out_valid_o;
  logic [127:0] out_data_o;
  logic         out_last_o;
  logic         out_ready_i = 1'b0;
  logic         busy_o;
  logic         done_o;

  int passed = 0;
  int total  = 0;

  rocket_trace_reader dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .trace_ptr_i(trace_ptr_i), .trace_count_i(trace_count_i),
    .trace_mem_en_o(trace_mem_en_o), .trace_mem_addr_o(trace_mem_addr_o),
    .trace_mem_rdata_i(trace_mem_rdata_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_5A5A, a + 32'h1, a};
  endfunction

  // Buffer read port: data one cycle after enable, derived from the address.
  always @(posedge clk_i) if (trace_mem_en_o) trace_mem_rdata_i <= mem_word(trace_mem_addr_o);

  logic [31:0]  en_addr_q[$];
  int           en_rel_q[$];
  logic [127:0] beat_dat_q[$];
  logic         beat_last_q[$];
  int           beat_rel_q[$];
  int           done_rel_q[$];
  int           start_cyc = 0;
  bit           busy_seen = 0;
  int           overlap_err = 0;
  int           hold_err = 0;
  logic         pv = 0, pr = 0, pl = 0;
  logic [127:0] pd = '0;

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (trace_mem_en_o) begin
        en_addr_q.push_back(trace_mem_addr_o);
        en_rel_q.push_back(cyc - start_cyc + 1);
      end
      if (trace_mem_en_o && out_valid_o) overlap_err++;
      if (pv && !pr && (!out_valid_o || out_data_o !== pd || out_last_o !== pl)) hold_err++;
      if (out_valid_o && out_ready_i) begin
        beat_dat_q.push_back(out_data_o);
        beat_last_q.push_back(out_last_o);
        beat_rel_q.push_back(cyc - start_cyc + 1);
      end
      if (done_o) done_rel_q.push_back(cyc - start_cyc + 1);
      if (busy_o) busy_seen = 1;
      pv = out_valid_o; pr = out_ready_i; pd = out_data_o; pl = out_last_o;
    end else begin
      pv = 0;
    end
  end

  // Reference: oldest-first entry order, two beats per entry, byte addresses.
  logic [31:0] exp_addr[$];
  task automatic build_model(input logic [31:0] count, input logic [31:0] ptr);
    int n, p, idx;
    exp_addr.delete();
    n = (count > 32'd1024) ? 1024 : int'(count);
    p = int'(ptr % 32'd1024);
    for (int e = 0; e < n; e++) begin
      idx = (p - n + e + 2048) % 1024;
      for (int b = 0; b < 2; b++) exp_addr.push_back(BASE + 32'(idx * 32 + b * 16));
    end
  endtask

  task automatic clear_mon();
    en_addr_q.delete(); en_rel_q.delete(); beat_dat_q.delete(); beat_last_q.delete();
    beat_rel_q.delete(); done_rel_q.delete();
    busy_seen = 0; overlap_err = 0; hold_err = 0;
  endtask

  task automatic do_drain(input logic [31:0] count, input logic [31:0] ptr, input bit rnd,
                          input int inject_at, input int budget, output int timeout);
    clear_mon();
    @(posedge clk_i); #1;
    trace_count_i = count; trace_ptr_i = ptr; start_i = 1'b1;
    out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk_i); #1;
    start_cyc = cyc; start_i = 1'b0;
    trace_count_i = $urandom; trace_ptr_i = $urandom;
    timeout = 1;
    for (int k = 0; k < budget; k++) begin
      if (done_rel_q.size() > 0) begin timeout = 0; break; end
      start_i = (k == inject_at);
      if (k == inject_at) trace_count_i = 32'($urandom_range(1, 50));
      out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0; out_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (trace_mem_en_o !== 1'b0) $display("FAIL reset_en: got %b want 0", trace_mem_en_o); else passed++;
    total++; if (trace_mem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", trace_mem_addr_o); else passed++;
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid_o); else passed++;
    total++; if (out_data_o !== 128'h0) $display("FAIL reset_data: got %h want 0", out_data_o); else passed++;
    total++; if (out_last_o !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
    total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else passed++;
  endtask

  task automatic test_empty();
    int to;
    do_drain(32'd0, 32'd7, 1'b0, -1, 20, to);
    total++; if (to !== 0) $display("FAIL empty_timeout: no done within budget"); else passed++;
    total++; if (en_addr_q.size() != 0) $display("FAIL empty_en: got %0d reads want 0", en_addr_q.size()); else passed++;
    total++; if (beat_dat_q.size() != 0) $display("FAIL empty_beats: got %0d want 0", beat_dat_q.size()); else passed++;
    total++; if (done_rel_q.size() != 1 || done_rel_q[0] != 1)
      $display("FAIL empty_done: got %0d pulses first at %0d want 1 at 1", done_rel_q.size(), done_rel_q[0]); else passed++;
    total++; if (busy_seen !== 1'b0) $display("FAIL empty_busy: got busy=%b want 0", busy_seen); else passed++;
  endtask

  task automatic test_three();
    int to;
    logic [31:0] exp3[6] = '{32'h100000, 32'h100010, 32'h100020, 32'h100030, 32'h100040, 32'h100050};
    do_drain(32'd3, 32'd3, 1'b0, -1, 100, to);
    total++; if (to !== 0) $display("FAIL three_timeout: no done within budget"); else passed++;
    total++; if (en_addr_q.size() != 6) $display("FAIL three_reads: got %0d want 6", en_addr_q.size()); else passed++;
    total++; if (beat_dat_q.size() != 6) $display("FAIL three_beats: got %0d want 6", beat_dat_q.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (en_addr_q[i] !== exp3[i]) $display("FAIL three_addr[%0d]: got %h want %h", i, en_addr_q[i], exp3[i]); else passed++;
      total++; if (beat_dat_q[i] !== mem_word(exp3[i])) $display("FAIL three_data[%0d]: got %h want %h", i, beat_dat_q[i], mem_word(exp3[i])); else passed++;
      total++; if (beat_last_q[i] !== (i == 5)) $display("FAIL three_last[%0d]: got %b want %b", i, beat_last_q[i], (i == 5)); else passed++;
    end
    total++; if (en_rel_q[0] != 1) $display("FAIL three_en_cycle: got %0d want 1", en_rel_q[0]); else passed++;
    total++; if (beat_rel_q[0] != 3) $display("FAIL three_valid_cycle: got %0d want 3", beat_rel_q[0]); else passed++;
    total++; if (done_rel_q.size() != 1 || done_rel_q[0] != 18)
      $display("FAIL three_done: got %0d pulses at %0d want 1 at 18", done_rel_q.size(), done_rel_q[0]); else passed++;
    total++; if (overlap_err != 0) $display("FAIL three_en_overlap: got %0d want 0", overlap_err); else passed++;
  endtask

  task automatic test_full_wrap();
    int to, errs;
    do_drain(32'd1024, 32'd5, 1'b0, -1, 7000, to);
    build_model(32'd1024, 32'd5);
    total++; if (to !== 0) $display("FAIL full_timeout: no done within budget"); else passed++;
    total++; if (beat_dat_q.size() != 2048) $display("FAIL full_beats: got %0d want 2048", beat_dat_q.size()); else passed++;
    total++; if (en_addr_q[0] !== 32'h1000A0) $display("FAIL full_first: got %h want 001000a0", en_addr_q[0]); else passed++;
    total++; if (en_addr_q[2047] !== 32'h100090) $display("FAIL full_lastaddr: got %h want 00100090", en_addr_q[2047]); else passed++;
    total++; if (en_addr_q[2036] !== BASE + 32'd1023 * 32'd32 || en_addr_q[2038] !== BASE)
      $display("FAIL full_wrap: got %h,%h want %h,%h", en_addr_q[2036], en_addr_q[2038], BASE + 32'd1023 * 32'd32, BASE); else passed++;
    total++; if (done_rel_q.size() != 1 || done_rel_q[0] != 6144)
      $display("FAIL full_done: got %0d pulses at %0d want 1 at 6144", done_rel_q.size(), done_rel_q[0]); else passed++;
    errs = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (en_addr_q[i] !== exp_addr[i] || beat_dat_q[i] !== mem_word(exp_addr[i]) || beat_last_q[i] !== (i == 2047)) errs++;
    total++; if (errs != 0) $display("FAIL full_order: got %0d bad beats want 0", errs); else passed++;
  endtask

  task automatic test_saturate();
    int to, errs;
    logic [31:0] ptr;
    ptr = $urandom;
    do_drain(32'd2000, ptr, 1'b0, -1, 7000, to);
    build_model(32'd2000, ptr);
    total++; if (to !== 0) $display("FAIL sat_timeout: no done within budget"); else passed++;
    total++; if (beat_dat_q.size() != 2048) $display("FAIL sat_beats: got %0d want 2048", beat_dat_q.size()); else passed++;
    errs = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (en_addr_q[i] !== exp_addr[i] || beat_dat_q[i] !== mem_word(exp_addr[i])) errs++;
    total++; if (errs != 0) $display("FAIL sat_order: got %0d bad beats want 0", errs); else passed++;
  endtask

  task automatic test_random_ready();
    int to;
    logic [31:0] cnt, ptr;
    for (int r = 0; r < 4; r++) begin
      cnt = 32'($urandom_range(1, 40));
      ptr = $urandom;
      do_drain(cnt, ptr, 1'b1, -1, 3000, to);
      build_model(cnt, ptr);
      total++; if (to !== 0) $display("FAIL rr%0d_timeout: no done within budget", r); else passed++;
      total++; if (beat_dat_q.size() != exp_addr.size())
        $display("FAIL rr%0d_beats: got %0d want %0d", r, beat_dat_q.size(), exp_addr.size()); else passed++;
      for (int i = 0; i < exp_addr.size(); i++) begin
        total++; if (en_addr_q[i] !== exp_addr[i]) $display("FAIL rr%0d_addr[%0d]: got %h want %h", r, i, en_addr_q[i], exp_addr[i]); else passed++;
        total++; if (beat_dat_q[i] !== mem_word(exp_addr[i])) $display("FAIL rr%0d_data[%0d]: got %h want %h", r, i, beat_dat_q[i], mem_word(exp_addr[i])); else passed++;
        total++; if (beat_last_q[i] !== (i == exp_addr.size() - 1)) $display("FAIL rr%0d_last[%0d]: got %b", r, i, beat_last_q[i]); else passed++;
      end
      total++; if (hold_err != 0) $display("FAIL rr%0d_stable: got %0d changes under stall want 0", r, hold_err); else passed++;
      total++; if (done_rel_q.size() != 1) $display("FAIL rr%0d_done: got %0d pulses want 1", r, done_rel_q.size()); else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    int to, errs;
    logic [31:0] ptr;
    ptr = $urandom;
    do_drain(32'd4, ptr, 1'b0, 5, 200, to);
    build_model(32'd4, ptr);
    total++; if (to !== 0) $display("FAIL busy_timeout: no done within budget"); else passed++;
    total++; if (beat_dat_q.size() != 8) $display("FAIL busy_beats: got %0d want 8", beat_dat_q.size()); else passed++;
    errs = 0;
    for (int i = 0; i < exp_addr.size(); i++) if (en_addr_q[i] !== exp_addr[i]) errs++;
    total++; if (errs != 0) $display("FAIL busy_order: got %0d bad reads want 0", errs); else passed++;
    total++; if (done_rel_q.size() != 1) $display("FAIL busy_done: got %0d pulses want 1", done_rel_q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    @(posedge clk_i); #1;
    trace_count_i = 32'd2; trace_ptr_i = $urandom; start_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_cyc = cyc; start_i = 1'b0;
    for (int k = 0; k < 50 && beat_dat_q.size() == 0; k++) begin @(posedge clk_i); #1; end
    total++; if (beat_dat_q.size() != 1) $display("FAIL rst_first_beat: got %0d beats want 1", beat_dat_q.size()); else passed++;
    reset_n_i = 1'b0;
    #1;
    total++; if (trace_mem_en_o !== 1'b0) $display("FAIL rst_en: got %b want 0", trace_mem_en_o); else passed++;
    total++; if (out_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid_o); else passed++;
    total++; if (out_data_o !== 128'h0) $display("FAIL rst_data: got %h want 0", out_data_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else passed++;
    total++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", done_o); else passed++;
    repeat (3) @(posedge clk_i);
    #1; reset_n_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    total++; if (done_rel_q.size() != 0) $display("FAIL rst_no_done: got %0d pulses want 0", done_rel_q.size()); else passed++;
    total++; if (busy_o !== 1'b0 || beat_dat_q.size() != 1)
      $display("FAIL rst_idle: got busy=%b beats=%0d want 0,1", busy_o, beat_dat_q.size()); else passed++;
  endtask

  initial begin
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1; reset_n_i = 1'b1;
    test_reset();
    test_empty();
    test_three();
    test_full_wrap();
    test_saturate();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
